fifo16_sync: RTL and testbench

- Synchronous single-clock FIFO for 16-bit datapath words. It provides the read side to match the existing store-enable register (reg16) write side.
- A producer pushes with a write strobe; a consumer pops with a read strobe. Data is show-ahead: the head word is always visible on rd_data.
- Intended placement is between datapath stages that cannot stall in lockstep, such as a result queue ahead of a writeback mux.

---
 rtl/fifo16_pkg.sv | 10 +
 rtl/fifo16_mem.sv | 22 ++
 rtl/fifo16_sync.sv | 66 ++++++
 tb/tb_fifo16_sync.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo16_pkg.sv
// Shared word type and helpers for the 16-bit synchronous FIFO.
package fifo16_pkg;
  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction
endpackage

// File: rtl/fifo16_mem.sv
// DEPTH x 16 storage: one synchronous write port, one asynchronous read port, no reset.
module fifo16_mem
  import fifo16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);
  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo16_sync.sv
// Single-clock show-ahead FIFO for 16-bit words with registered overflow/underflow pulses.
module fifo16_sync
  import fifo16_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              underflow
);
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("fifo16_sync: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Flags decode the registered count only, so storage contents never reach them.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = wr_en & (~full | rd_en);
  assign do_pop  = rd_en & ~empty;

  fifo16_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (do_push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en & full & ~rd_en;
      underflow <= rd_en & empty;
    end
  end
endmodule

// File: tb/tb_fifo16_sync.sv
// Directed table-driven bench for fifo16_sync (DEPTH=4) plus reset and wrap-around sequences.
module tb_fifo16_sync;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        full, empty, overflow, underflow;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  fifo16_sync #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] wd;
    logic        rd;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic        ovf;
    logic        unf;
    logic        chk_d;
    logic [15:0] d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic wr, logic [15:0] wd, logic rd, int cnt,
                              logic e, logic f, logic o, logic u,
                              logic cd, logic [15:0] d);
    vec_t v;
    v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = 3'(cnt);
    v.emp = e; v.ful = f; v.ovf = o; v.unf = u; v.chk_d = cd; v.d = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag, input int cnt, input logic e, input logic f,
                             input logic o, input logic u);
    check({tag, " count"},     16'(count),     16'(cnt));
    check({tag, " empty"},     16'(empty),     16'(e));
    check({tag, " full"},      16'(full),      16'(f));
    check({tag, " overflow"},  16'(overflow),  16'(o));
    check({tag, " underflow"}, 16'(underflow), 16'(u));
  endtask

  task automatic cycle(input logic wr, input logic [15:0] wd, input logic rd);
    @(negedge clk);
    wr_en = wr; wr_data = wd; rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset, then idle.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    check_flags("reset_idle", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-fill.
    cycle(1'b1, 16'h0AA1, 1'b0);
    cycle(1'b1, 16'h0AA2, 1'b0);
    cycle(1'b1, 16'h0AA3, 1'b0);
    check("midfill count", 16'(count), 16'd3);
    @(negedge clk);
    wr_en = 1'b0;
    reset = 1'b1;
    #1;
    check_flags("async_reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: fill/drain, overflow, push+pop when full, underflow, push+pop when empty.
    tbl.push_back(mk(1, 16'h1111, 0, 1, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h2222, 0, 2, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h3333, 0, 3, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h4444, 0, 4, 0, 1, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(0, 16'h0000, 1, 3, 0, 0, 0, 0, 1, 16'h2222));
    tbl.push_back(mk(0, 16'h0000, 1, 2, 0, 0, 0, 0, 1, 16'h3333));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 0, 0, 1, 16'h4444));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h1111, 0, 1, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h2222, 0, 2, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h3333, 0, 3, 0, 0, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'h4444, 0, 4, 0, 1, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'hDEAD, 0, 4, 0, 1, 1, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'hDEAD, 0, 4, 0, 1, 1, 0, 1, 16'h1111));
    tbl.push_back(mk(0, 16'h0000, 0, 4, 0, 1, 0, 0, 1, 16'h1111));
    tbl.push_back(mk(1, 16'hBEEF, 1, 4, 0, 1, 0, 0, 1, 16'h2222));
    tbl.push_back(mk(0, 16'h0000, 1, 3, 0, 0, 0, 0, 1, 16'h3333));
    tbl.push_back(mk(0, 16'h0000, 1, 2, 0, 0, 0, 0, 1, 16'h4444));
    tbl.push_back(mk(0, 16'h0000, 1, 1, 0, 0, 0, 0, 1, 16'hBEEF));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 0, 1, 0, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h00A5, 1, 1, 0, 0, 0, 1, 1, 16'h00A5));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 0, 0, 1, 16'h00A5));
    tbl.push_back(mk(0, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 16'h0000));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      cycle(tbl[i].wr, tbl[i].wd, tbl[i].rd);
      check_flags(tag, int'(tbl[i].cnt), tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].unf);
      if (tbl[i].chk_d) check({tag, " rd_data"}, rd_data, tbl[i].d);
    end

    // Wrap-around with count held at 2.
    cycle(1'b1, 16'h0001, 1'b0);
    cycle(1'b1, 16'h0002, 1'b0);
    check("wrap prefill count", 16'(count), 16'd2);
    for (int unsigned w = 3; w <= 10; w++) begin
      @(negedge clk);
      check($sformatf("wrap head%0d", w - 2), rd_data, 16'(w - 2));
      wr_en = 1'b1; wr_data = 16'(w); rd_en = 1'b1;
      @(posedge clk);
      #1;
      check_flags($sformatf("wrap pair%0d", w), 2, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int unsigned w = 9; w <= 10; w++) begin
      @(negedge clk);
      check($sformatf("wrap head%0d", w), rd_data, 16'(w));
      wr_en = 1'b0; rd_en = 1'b1;
      @(posedge clk);
      #1;
    end
    check_flags("wrap drained", 0, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
